calc_entry_display_ctrl: RTL and testbench
==========================================

# calc_entry_display_ctrl

Sequencer between the calculator keypad decoder, the arithmetic unit and the VGA painter. Accepts decoded key codes, builds a BCD operand digit by digit, hands it to the arithmetic unit over a valid/ready handshake, and loads the returned result. Drives the painter's `numActual`/`counterTotal` inputs from shadow registers that update only at frame start, so a frame never shows a half-updated value.

## Interface

Parameters:
- `MAX_DIGITS`, default 10: maximum BCD digits held. `numActual` width is 4*MAX_DIGITS, i.e. 40 at the default.

Ports:
- `clk_100MHz`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  key code present.
- `key_code`  in  4  key: 0x0–0x9 digit, 0xA backspace, 0xB clear, 0xC enter; 0xD–0xF ignored.
- `key_ready`  out  1  key accepted on an edge where `key_valid && key_ready`.
- `op_valid`  out  1  operand offered to the arithmetic unit.
- `op_bcd`  out  40  operand, BCD, least-significant digit in [3:0].
- `op_digits`  out  4  operand digit count, 1..MAX_DIGITS.
- `op_ready`  in  1  arithmetic unit takes the operand.
- `res_valid`  in  1  result strobe, one cycle.
- `res_bcd`  in  40  result, BCD.
- `res_digits`  in  4  result digit count.
- `frame_start`  in  1  one-cycle pulse per VGA frame, at the start of vertical blanking.
- `numActual`  out  40  displayed value, to the painter.
- `counterTotal`  out  4  displayed digit count, to the painter.
- `ovf`  out  1  sticky flag: a digit was dropped because the buffer was full.

## Operation

- Internal working registers: `buf` (40 bits) and `cnt` (4 bits).
- FSM states and `key_ready` in each:
  - ENTRY: 1.
  - SEND: 0.
  - WAIT_RES: 0.
  - RESULT: 1.
- ENTRY, accepted key:
  - Digit d, `cnt` < MAX_DIGITS: `buf` <= {buf[35:0], d}, `cnt`+1.
  - Exception: d=0 with `cnt`=0 changes nothing (no leading zeros).
  - Digit with `cnt`=MAX_DIGITS: dropped, `ovf` <= 1.
  - Backspace: `buf` <= buf>>4, `cnt`-1. No effect when `cnt`=0.
  - Clear: `buf`, `cnt` and `ovf` <= 0.
  - Enter: go to SEND.
  - Codes 0xD–0xF: consumed, no effect.
- SEND:
  - `op_valid`=1; `op_bcd`=`buf`; `op_digits`=max(`cnt`,1).
  - `op_bcd`/`op_digits` held stable until the transfer edge (`op_valid && op_ready`).
  - Transfer edge -> WAIT_RES.
- WAIT_RES:
  - `res_valid` loads `buf` <= `res_bcd`, `cnt` <= `res_digits`, then -> RESULT.
  - `res_digits` of 0 loads 1; values above MAX_DIGITS load MAX_DIGITS.
- RESULT:
  - Digit: `buf` <= {36'b0, d}, `cnt` <= (d==0 ? 0 : 1), `ovf` <= 0, -> ENTRY.
  - Clear: as in ENTRY, then -> ENTRY.
  - Backspace: ignored.
  - Enter: -> SEND, with the result as the operand (chaining).
- `res_valid` outside WAIT_RES: ignored.
- Display shadow: on a `frame_start` edge, `numActual` <= `buf` and `counterTotal` <= `cnt`. Otherwise both hold.

## Timing

- Reset: all outputs and registers 0, state ENTRY. `key_ready`=1 as soon as reset deasserts.
- `key_ready` and `op_valid` are decoded from the state register only; no combinational path from any input.
- Key to `buf`: 1 cycle. Key to display: visible the cycle after the next `frame_start`.
- Enter accepted at edge N: `op_valid`=1 from N+1.
- Transfer at edge M: `op_valid`=0 and state WAIT_RES from M+1. `op_ready` held high gives a single transfer.
- `res_valid` at edge R: state RESULT and `key_ready`=1 from R+1.
- Simultaneous key accept and `frame_start`: the shadow takes the pre-update `buf`; the new value appears at the following frame.
- Reset asserted mid-SEND or mid-WAIT_RES: immediate return to the reset state. A result arriving afterwards is ignored.

## Test plan

- Reset, then keys 1,2,3, one `frame_start` -> `numActual`=0x123, `counterTotal`=3. Before that `frame_start`, both stay 0.
- Keys 0,0,7 then backspace twice -> `cnt`=0, `buf`=0. Then 11 digits 9 -> `buf`=0x9999999999, `cnt`=10, `ovf`=1. Clear -> `ovf`=0.
- Keys 4,2,enter with `op_ready` low for 5 cycles -> `op_valid` high 5 cycles, `op_bcd`=0x42 and `op_digits`=2 stable. On `op_ready`: one transfer, `key_ready` stays 0.
- In WAIT_RES, `res_valid` with 0x1764 and 4 digits -> RESULT; after `frame_start`, `numActual`=0x1764. Then key 5 -> `buf`=0x5, `cnt`=1, state ENTRY.
- Enter in RESULT with 0x1764 -> `op_bcd`=0x1764, `op_digits`=4. `res_digits`=0 -> `cnt`=1; `res_digits`=12 -> `cnt`=10.
- `rst_n` low during SEND -> `op_valid`=0 at once. After release, a `res_valid` pulse is ignored and the state is ENTRY.

Source files
------------

// File: rtl/calc_entry_display_ctrl.sv
// Keypad-to-ALU sequencer: builds a BCD operand from key codes, hands it off over valid/ready,
// loads the result back and mirrors the working value into frame-synchronous display registers.
module calc_entry_display_ctrl #(
   parameter int MAX_DIGITS = 10
) (
   input  logic                    clk_100MHz,
   input  logic                    rst_n,
   input  logic                    key_valid,
   input  logic [3:0]              key_code,
   output logic                    key_ready,
   output logic                    op_valid,
   output logic [4*MAX_DIGITS-1:0] op_bcd,
   output logic [3:0]              op_digits,
   input  logic                    op_ready,
   input  logic                    res_valid,
   input  logic [4*MAX_DIGITS-1:0] res_bcd,
   input  logic [3:0]              res_digits,
   input  logic                    frame_start,
   output logic [4*MAX_DIGITS-1:0] numActual,
   output logic [3:0]              counterTotal,
   output logic                    ovf,
   output logic [1:0]              dbg_state
);

   localparam int          BW      = 4 * MAX_DIGITS;
   localparam logic [3:0]  MAX_CNT = 4'(MAX_DIGITS);

   // Handshakes: a key moves on an edge with key_valid && key_ready; the operand moves on an
   // edge with op_valid && op_ready and op_bcd/op_digits hold steady until then; res_valid is a
   // one-cycle strobe honoured only while waiting for a result.
   typedef enum logic [1:0] {
      ST_ENTRY    = 2'd0,
      ST_SEND     = 2'd1,
      ST_WAIT_RES = 2'd2,
      ST_RESULT   = 2'd3
   } state_t;

   state_t          state, state_n;
   logic [BW-1:0]   work_buf, buf_n;
   logic [3:0]      work_cnt, cnt_n;
   logic            ovf_q, ovf_n;
   logic            key_accept;
   logic            is_digit;

   assign key_ready  = (state == ST_ENTRY) || (state == ST_RESULT);
   assign op_valid   = (state == ST_SEND);
   assign op_bcd     = work_buf;
   assign op_digits  = (work_cnt == 4'd0) ? 4'd1 : work_cnt;
   assign ovf        = ovf_q;
   assign dbg_state  = state;
   assign key_accept = key_valid && key_ready;
   assign is_digit   = (key_code <= 4'h9);

   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_ENTRY;
         work_buf <= '0;
         work_cnt <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state    <= state_n;
         work_buf <= buf_n;
         work_cnt <= cnt_n;
         ovf_q    <= ovf_n;
      end
   end

   always_comb begin
      state_n = state;
      buf_n   = work_buf;
      cnt_n   = work_cnt;
      ovf_n   = ovf_q;
      case (state)
         ST_ENTRY: begin
            if (key_accept) begin
               if (is_digit) begin
                  if (work_cnt >= MAX_CNT) begin
                     ovf_n = 1'b1;
                  end else if (!(key_code == 4'h0 && work_cnt == 4'd0)) begin
                     buf_n = {work_buf[BW-5:0], key_code};
                     cnt_n = work_cnt + 4'd1;
                  end
               end else if (key_code == 4'hA) begin
                  if (work_cnt != 4'd0) begin
                     buf_n = work_buf >> 4;
                     cnt_n = work_cnt - 4'd1;
                  end
               end else if (key_code == 4'hB) begin
                  buf_n = '0;
                  cnt_n = '0;
                  ovf_n = 1'b0;
               end else if (key_code == 4'hC) begin
                  state_n = ST_SEND;
               end
            end
         end
         ST_SEND: begin
            if (op_ready) state_n = ST_WAIT_RES;
         end
         ST_WAIT_RES: begin
            if (res_valid) begin
               buf_n = res_bcd;
               if (res_digits == 4'd0)        cnt_n = 4'd1;
               else if (res_digits > MAX_CNT) cnt_n = MAX_CNT;
               else                           cnt_n = res_digits;
               state_n = ST_RESULT;
            end
         end
         ST_RESULT: begin
            // A fresh digit starts a new number; backspace cannot edit a result.
            if (key_accept) begin
               if (is_digit) begin
                  buf_n   = {{(BW-4){1'b0}}, key_code};
                  cnt_n   = (key_code == 4'h0) ? 4'd0 : 4'd1;
                  ovf_n   = 1'b0;
                  state_n = ST_ENTRY;
               end else if (key_code == 4'hB) begin
                  buf_n   = '0;
                  cnt_n   = '0;
                  ovf_n   = 1'b0;
                  state_n = ST_ENTRY;
               end else if (key_code == 4'hC) begin
                  state_n = ST_SEND;
               end
            end
         end
         default: state_n = ST_ENTRY;
      endcase
   end

   // Shadow copy taken only at frame start so the painter never sees a partial update.
   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         numActual    <= '0;
         counterTotal <= '0;
      end else if (frame_start) begin
         numActual    <= work_buf;
         counterTotal <= work_cnt;
      end
   end

endmodule

// File: tb/tb_calc_entry_display_ctrl.sv
// Directed bench for calc_entry_display_ctrl: key entry, editing, operand handoff,
// result loading, frame-synchronous display and reset during a transfer.
module tb_calc_entry_display_ctrl;

   localparam int BW = 40;

   logic          clk_100MHz = 1'b0;
   logic          rst_n      = 1'b0;
   logic          key_valid  = 1'b0;
   logic [3:0]    key_code   = 4'h0;
   logic          key_ready;
   logic          op_valid;
   logic [BW-1:0] op_bcd;
   logic [3:0]    op_digits;
   logic          op_ready   = 1'b0;
   logic          res_valid  = 1'b0;
   logic [BW-1:0] res_bcd    = '0;
   logic [3:0]    res_digits = 4'd0;
   logic          frame_start = 1'b0;
   logic [BW-1:0] numActual;
   logic [3:0]    counterTotal;
   logic          ovf;
   logic [1:0]    dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_100MHz = ~clk_100MHz;

   calc_entry_display_ctrl #(.MAX_DIGITS(10)) dut (
      .clk_100MHz   (clk_100MHz),
      .rst_n        (rst_n),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .key_ready    (key_ready),
      .op_valid     (op_valid),
      .op_bcd       (op_bcd),
      .op_digits    (op_digits),
      .op_ready     (op_ready),
      .res_valid    (res_valid),
      .res_bcd      (res_bcd),
      .res_digits   (res_digits),
      .frame_start  (frame_start),
      .numActual    (numActual),
      .counterTotal (counterTotal),
      .ovf          (ovf),
      .dbg_state    (dbg_state)
   );

   task automatic press(input logic [3:0] code);
      @(negedge clk_100MHz);
      key_valid = 1'b1;
      key_code  = code;
      @(negedge clk_100MHz);
      key_valid = 1'b0;
   endtask

   task automatic pulse_frame();
      @(negedge clk_100MHz);
      frame_start = 1'b1;
      @(negedge clk_100MHz);
      frame_start = 1'b0;
   endtask

   task automatic pulse_result(input logic [BW-1:0] val, input logic [3:0] digits);
      @(negedge clk_100MHz);
      res_valid  = 1'b1;
      res_bcd    = val;
      res_digits = digits;
      @(negedge clk_100MHz);
      res_valid  = 1'b0;
   endtask

   task automatic transfer();
      @(negedge clk_100MHz);
      op_ready = 1'b1;
      @(negedge clk_100MHz);
      op_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk_100MHz);
      rst_n = 1'b1;
      @(negedge clk_100MHz);
      n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL reset_key_ready: got %b want 1", key_ready); end
      n_cmp++; if (op_valid !== 1'b0) begin n_bad++; $display("FAIL reset_op_valid: got %b want 0", op_valid); end
      n_cmp++; if (numActual !== 40'h0 || counterTotal !== 4'd0) begin n_bad++; $display("FAIL reset_display: got %h/%0d want 0/0", numActual, counterTotal); end
      n_cmp++; if (ovf !== 1'b0 || dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_ovf_state: got %b/%0d want 0/0", ovf, dbg_state); end
   endtask

   task automatic test_entry();
      press(4'h1); press(4'h2); press(4'h3);
      n_cmp++; if (numActual !== 40'h0 || counterTotal !== 4'd0) begin n_bad++; $display("FAIL entry_pre_frame: got %h/%0d want 0/0", numActual, counterTotal); end
      pulse_frame();
      n_cmp++; if (numActual !== 40'h123 || counterTotal !== 4'd3) begin n_bad++; $display("FAIL entry_123: got %h/%0d want 123/3", numActual, counterTotal); end
   endtask

   task automatic test_edit();
      press(4'hB);
      press(4'h0); press(4'h0); press(4'h7);
      pulse_frame();
      n_cmp++; if (numActual !== 40'h7 || counterTotal !== 4'd1) begin n_bad++; $display("FAIL edit_leading_zero: got %h/%0d want 7/1", numActual, counterTotal); end
      press(4'hA); press(4'hA);
      pulse_frame();
      n_cmp++; if (numActual !== 40'h0 || counterTotal !== 4'd0) begin n_bad++; $display("FAIL edit_backspace: got %h/%0d want 0/0", numActual, counterTotal); end
      for (int i = 0; i < 11; i++) press(4'h9);
      pulse_frame();
      n_cmp++; if (numActual !== 40'h9999999999 || counterTotal !== 4'd10) begin n_bad++; $display("FAIL edit_full: got %h/%0d want 9999999999/10", numActual, counterTotal); end
      n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL edit_ovf_set: got %b want 1", ovf); end
      press(4'hB);
      pulse_frame();
      n_cmp++; if (ovf !== 1'b0 || numActual !== 40'h0 || counterTotal !== 4'd0) begin n_bad++; $display("FAIL edit_clear: got ovf %b %h/%0d want 0 0/0", ovf, numActual, counterTotal); end
      press(4'h5); press(4'hD); press(4'hF);
      pulse_frame();
      n_cmp++; if (numActual !== 40'h5 || counterTotal !== 4'd1) begin n_bad++; $display("FAIL edit_ignored_codes: got %h/%0d want 5/1", numActual, counterTotal); end
      press(4'hB);
   endtask

   task automatic test_send();
      press(4'h4); press(4'h2); press(4'hC);
      // A key offered while sending must not be taken.
      key_valid = 1'b1;
      key_code  = 4'h9;
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (op_valid !== 1'b1 || key_ready !== 1'b0) begin n_bad++; $display("FAIL send_hold_%0d: got valid %b ready %b want 1 0", i, op_valid, key_ready); end
         n_cmp++; if (op_bcd !== 40'h42 || op_digits !== 4'd2) begin n_bad++; $display("FAIL send_operand_%0d: got %h/%0d want 42/2", i, op_bcd, op_digits); end
         @(negedge clk_100MHz);
      end
      key_valid = 1'b0;
      op_ready  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_100MHz);
         n_cmp++; if (op_valid !== 1'b0 || dbg_state !== 2'd2 || key_ready !== 1'b0) begin n_bad++; $display("FAIL send_transfer_%0d: got valid %b state %0d ready %b want 0 2 0", i, op_valid, dbg_state, key_ready); end
      end
      op_ready = 1'b0;
   endtask

   task automatic test_result();
      pulse_result(40'h1764, 4'd4);
      n_cmp++; if (dbg_state !== 2'd3 || key_ready !== 1'b1) begin n_bad++; $display("FAIL result_state: got %0d ready %b want 3 1", dbg_state, key_ready); end
      pulse_frame();
      n_cmp++; if (numActual !== 40'h1764 || counterTotal !== 4'd4) begin n_bad++; $display("FAIL result_display: got %h/%0d want 1764/4", numActual, counterTotal); end
      press(4'hA);
      press(4'hC);
      n_cmp++; if (op_valid !== 1'b1 || op_bcd !== 40'h1764 || op_digits !== 4'd4) begin n_bad++; $display("FAIL result_chain: got %b %h/%0d want 1 1764/4", op_valid, op_bcd, op_digits); end
      transfer();
      pulse_result(40'h0, 4'd0);
      pulse_frame();
      n_cmp++; if (counterTotal !== 4'd1 || numActual !== 40'h0) begin n_bad++; $display("FAIL result_digits_zero: got %h/%0d want 0/1", numActual, counterTotal); end
      press(4'hC);
      n_cmp++; if (op_digits !== 4'd1) begin n_bad++; $display("FAIL result_op_digits_min: got %0d want 1", op_digits); end
      transfer();
      pulse_result(40'h321, 4'd12);
      pulse_frame();
      n_cmp++; if (counterTotal !== 4'd10 || numActual !== 40'h321) begin n_bad++; $display("FAIL result_digits_clamp: got %h/%0d want 321/10", numActual, counterTotal); end
      press(4'h5);
      pulse_frame();
      n_cmp++; if (numActual !== 40'h5 || counterTotal !== 4'd1 || dbg_state !== 2'd0) begin n_bad++; $display("FAIL result_new_digit: got %h/%0d state %0d want 5/1 0", numActual, counterTotal, dbg_state); end
   endtask

   task automatic test_back_to_back();
      // Key accept and frame_start on the same edge: shadow keeps the old value.
      @(negedge clk_100MHz);
      key_valid   = 1'b1;
      key_code    = 4'h6;
      frame_start = 1'b1;
      @(negedge clk_100MHz);
      key_valid   = 1'b0;
      frame_start = 1'b0;
      n_cmp++; if (numActual !== 40'h5 || counterTotal !== 4'd1) begin n_bad++; $display("FAIL b2b_same_edge: got %h/%0d want 5/1", numActual, counterTotal); end
      pulse_frame();
      n_cmp++; if (numActual !== 40'h56 || counterTotal !== 4'd2) begin n_bad++; $display("FAIL b2b_next_frame: got %h/%0d want 56/2", numActual, counterTotal); end
   endtask

   task automatic test_reset_mid_send();
      press(4'hB); press(4'h8); press(4'hC);
      n_cmp++; if (op_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_send: got %b want 1", op_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (op_valid !== 1'b0 || key_ready !== 1'b1) begin n_bad++; $display("FAIL rst_async: got valid %b ready %b want 0 1", op_valid, key_ready); end
      @(negedge clk_100MHz);
      rst_n = 1'b1;
      pulse_result(40'h99, 4'd2);
      n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL rst_late_result_state: got %0d want 0", dbg_state); end
      pulse_frame();
      n_cmp++; if (numActual !== 40'h0 || counterTotal !== 4'd0) begin n_bad++; $display("FAIL rst_late_result_display: got %h/%0d want 0/0", numActual, counterTotal); end
   endtask

   initial begin
      test_reset();
      test_entry();
      test_edit();
      test_send();
      test_result();
      test_back_to_back();
      test_reset_mid_send();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
